dmem_sram_bridge: RTL

- Sits directly downstream of the memory-access stage, between its single-cycle data-SRAM request outputs (dce/we/dre/daddr/din) and the SoC's SRAM-like data bus (req/addr_ok/data_ok handshake).
- Converts each request into exactly one bus transaction and converts lane order between the pipeline's byte-swapped convention and the bus's little-endian convention.
- Stalls the pipeline until the transaction completes, then presents load data to the write-back path for one cycle.

---
 rtl/dmem_sram_bridge.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge
//   Turns each single-cycle data-SRAM request from the memory-access stage
//   into exactly one SRAM-like bus transaction (req/addr_ok/data_ok). It
//   stalls the pipeline until the response arrives, then presents load data
//   for one cycle. Lane order differs on the two sides: the pipeline uses
//   byte-swapped order and the bus uses little-endian order.
//
// Ports
//   cpu_clk_50M, cpu_rst_n        clock, synchronous active-low reset
//   dce, we, dre, daddr, din      mem-stage request (masks in pipeline order)
//   flush                         exception/eret flush of the pipeline
//   data_req .. data_wdata        bus request channel (registered)
//   data_addr_ok, data_data_ok,
//   data_rdata                    bus handshake / response
//   stall_req                     combinational stall to the stall controller
//   dm, dm_valid                  load data (pipeline order) and its strobe
//
// state | meaning
// IDLE  | no transaction; watches the mem stage for an access
// REQ   | data_req high, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | one cycle; load data presented, pipeline released
module dmem_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              dce,
  input  logic [3:0]        we,
  input  logic [3:0]        dre,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] din,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall_req,
  output logic [DATA_W-1:0] dm,
  output logic              dm_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  mask;
  logic [2:0]  lane_cnt;
  logic        acc;
  logic [1:0]  size_nx;
  logic        is_load;
  logic        discard;
  logic        valid_q;

  // Stores take precedence when building the lane mask; a load never has
  // we set, so this only matters for malformed requests.
  assign mask     = (|we) ? we : dre;
  assign lane_cnt = {2'b00, mask[0]} + {2'b00, mask[1]} +
                    {2'b00, mask[2]} + {2'b00, mask[3]};

  // Only 1, 2 or 4 active lanes form a legal access; anything else is ignored.
  always_comb begin
    acc     = 1'b0;
    size_nx = 2'd0;
    case (lane_cnt)
      3'd1: begin acc = dce; size_nx = 2'd0; end
      3'd2: begin acc = dce; size_nx = 2'd1; end
      3'd4: begin acc = dce; size_nx = 2'd2; end
      default: begin acc = 1'b0; size_nx = 2'd0; end
    endcase
  end

  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        stall_req = acc;
        if (acc && !flush) state_nx = REQ;
      end
      REQ: begin
        stall_req = 1'b1;
        if (data_addr_ok) state_nx = data_data_ok ? DONE : WAIT;
      end
      WAIT: begin
        stall_req = 1'b1;
        if (data_data_ok) state_nx = DONE;
      end
      DONE: begin
        stall_req = 1'b0;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      dm         <= '0;
      valid_q    <= 1'b0;
      is_load    <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state    <= state_nx;
      data_req <= (state_nx == REQ);

      if (state == IDLE && state_nx == REQ) begin
        data_wr    <= |we;
        data_size  <= size_nx;
        data_addr  <= daddr;
        data_wdata <= {din[7:0], din[15:8], din[23:16], din[31:24]};
        is_load    <= ~(|we);
      end

      // A flushed transaction still drains on the bus; only its result is dropped.
      if (state_nx == IDLE)
        discard <= 1'b0;
      else if ((state == REQ || state == WAIT) && flush)
        discard <= 1'b1;

      valid_q <= 1'b0;
      if (state_nx == DONE) begin
        dm      <= {data_rdata[7:0], data_rdata[15:8], data_rdata[23:16], data_rdata[31:24]};
        valid_q <= is_load & ~discard & ~flush;
      end
    end
  end

  // A flush arriving in the DONE cycle itself still has to kill the write-back.
  assign dm_valid = valid_q & ~flush;

endmodule
